// File: rtl/instruction_parser.sv
// instruction_parser: turns the ASCII light-puzzle text into packed display
// instructions {op, start_row, start_col, end_row, end_col}. One completed
// instruction is held in reserve ("pend") so the output word can be tagged
// instr_last exactly, even when the text ends in blank lines.
//
// Handshakes: both ports are valid/ready. A transfer happens on a rising
// clock edge where valid && ready. A producer never drops valid or changes
// data/last while valid is high and ready is low. valid never waits on ready.
// in_ready is a function of registered state only.
module instruction_parser #(
    parameter int INSTRUCTION_WIDTH = 50,
    parameter int POSITION_BITS     = 12,
    parameter int ERROR_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic                         instr_last,
    output logic                         parse_done,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count,
    output logic [1:0]                   dbg_state
);

    typedef enum logic [1:0] {
        SM_PARSE = 2'd0,
        SM_FLUSH = 2'd1,
        SM_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_TURN_OFF = 2'b00;
    localparam logic [1:0] OP_TOGGLE   = 2'b01;
    localparam logic [1:0] OP_TURN_ON  = 2'b11;

    localparam logic [7:0] CH_CR = 8'h0d;
    localparam logic [7:0] CH_NL = 8'h0a;
    localparam logic [7:0] CH_O  = 8'h6f;
    localparam logic [7:0] CH_N  = 8'h6e;
    localparam logic [7:0] CH_F  = 8'h66;

    state_t                         state_q, state_d;
    logic                           ready_en_q, ready_en_d;
    logic [2:0]                     idx_q, idx_d;
    logic [1:0]                     op_q, op_d;
    logic [POSITION_BITS-1:0]       acc_q, acc_d;
    logic                           in_num_q, in_num_d;
    logic [2:0]                     fcnt_q, fcnt_d;
    logic [POSITION_BITS-1:0]       fld_q [4];
    logic [POSITION_BITS-1:0]       fld_d [4];
    logic                           pend_valid_q, pend_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic                           out_valid_q, out_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]   out_data_q, out_data_d;
    logic                           out_last_q, out_last_d;
    logic [ERROR_COUNT_WIDTH-1:0]   err_q, err_d;

    logic accept;
    logic is_cr;
    logic is_nl;
    logic is_digit;

    assign accept      = in_valid && in_ready;
    assign instr_valid = out_valid_q;
    assign instr_data  = out_data_q;
    assign instr_last  = out_last_q;
    assign error_count = err_q;

    // State register plus all datapath flops; everything clears on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SM_PARSE;
            ready_en_q   <= 1'b0;
            idx_q        <= '0;
            op_q         <= OP_TURN_OFF;
            acc_q        <= '0;
            in_num_q     <= 1'b0;
            fcnt_q       <= '0;
            fld_q        <= '{default: '0};
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= ready_en_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            in_num_q     <= in_num_d;
            fcnt_q       <= fcnt_d;
            fld_q        <= fld_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            err_q        <= err_d;
        end
    end

    // Next state: last input byte starts the flush, flush ends once nothing is left.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SM_PARSE: if (accept && in_last) state_d = SM_FLUSH;
            SM_FLUSH: if (!pend_valid_q && (!out_valid_q || instr_ready)) state_d = SM_DONE;
            SM_DONE:  state_d = SM_DONE;
            default:  state_d = SM_PARSE;
        endcase
    end

    // FSM outputs: input is accepted only while parsing and a completed line has a home.
    always_comb begin
        in_ready   = (state_q == SM_PARSE) && ready_en_q && !(out_valid_q && pend_valid_q);
        parse_done = (state_q == SM_DONE);
        dbg_state  = state_q;
    end

    // Byte parsing, line termination, reserve/output register movement.
    always_comb begin
        ready_en_d   = 1'b1;
        idx_d        = idx_q;
        op_d         = op_q;
        acc_d        = acc_q;
        in_num_d     = in_num_q;
        fcnt_d       = fcnt_q;
        fld_d        = fld_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        err_d        = err_q;

        is_cr    = (in_data == CH_CR);
        is_nl    = (in_data == CH_NL);
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);

        // A downstream accept frees the output register before anything else lands.
        if (out_valid_q && instr_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            // Op detection looks at fixed character positions within the line.
            if (!is_cr && !is_nl) begin
                if (idx_q == 3'd1 && in_data == CH_O) begin
                    op_d = OP_TOGGLE;
                end else if (idx_q == 3'd6 && op_q != OP_TOGGLE) begin
                    if (in_data == CH_N) op_d = OP_TURN_ON;
                    else if (in_data == CH_F) op_d = OP_TURN_OFF;
                end
                if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
            end

            if (is_digit) begin
                acc_d    = (acc_q << 3) + (acc_q << 1)
                         + {{(POSITION_BITS-4){1'b0}}, in_data[3:0]};
                in_num_d = 1'b1;
            end else if (!is_cr && in_num_q) begin
                if (fcnt_q < 3'd4) fld_d[fcnt_q[1:0]] = acc_q;
                fcnt_d   = (fcnt_q == 3'd5) ? 3'd5 : fcnt_q + 3'd1;
                acc_d    = '0;
                in_num_d = 1'b0;
            end

            if (is_nl || in_last) begin
                // A number running into the end of the line still counts.
                if (in_num_d) begin
                    if (fcnt_d < 3'd4) fld_d[fcnt_d[1:0]] = acc_d;
                    fcnt_d = (fcnt_d == 3'd5) ? 3'd5 : fcnt_d + 3'd1;
                end
                if (idx_d != 3'd0) begin
                    if (fcnt_d == 3'd4) begin
                        // in_ready guarantees the output register is free when pend is full.
                        if (pend_valid_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = pend_data_q;
                            out_last_d  = 1'b0;
                        end
                        pend_valid_d = 1'b1;
                        pend_data_d  = {op_d, fld_d[0], fld_d[1], fld_d[2], fld_d[3]};
                    end else if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end
                idx_d    = '0;
                op_d     = OP_TURN_OFF;
                acc_d    = '0;
                in_num_d = 1'b0;
                fcnt_d   = '0;
                fld_d    = '{default: '0};
            end

            // Entering flush with nothing in reserve: the held word is the final one.
            if (in_last && !pend_valid_d && out_valid_d) out_last_d = 1'b1;
        end

        if (state_q == SM_FLUSH && pend_valid_q && (!out_valid_q || instr_ready)) begin
            out_valid_d  = 1'b1;
            out_data_d   = pend_data_q;
            out_last_d   = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_parser.sv
// tb_instruction_parser: directed and randomized checks of instruction_parser.
// Random traffic is checked against a line-oriented text model.
module tb_instruction_parser;

    localparam int IW = 50;
    localparam int PB = 12;
    localparam int EW = 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instr_data;
    logic          instr_last;
    logic          parse_done;
    logic [EW-1:0] error_count;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    instruction_parser #(
        .INSTRUCTION_WIDTH(IW),
        .POSITION_BITS(PB),
        .ERROR_COUNT_WIDTH(EW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_last(instr_last),
        .parse_done(parse_done),
        .error_count(error_count),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [IW:0] exp_q[$];      // {last, data}
    logic [7:0]  stim_q[$];
    logic [7:0]  line_q[$];
    int          exp_err;
    bit          send_last = 1'b1;
    int          gap_pct = 0;

    localparam logic [IW-1:0] W_ON_FULL  = 50'h3_0000_003E_73E7;
    localparam logic [IW-1:0] W_TOG      = 50'h1_0000_003E_7000;
    localparam logic [IW-1:0] W_OFF_MID  = 50'h0_1F31_F31F_41F4;
    localparam logic [IW-1:0] W_BP1      = 50'h3_0010_0200_3004;
    localparam logic [IW-1:0] W_BP2      = 50'h1_00A0_1401_E028;
    localparam logic [IW-1:0] W_BP3      = 50'h0_FFF0_0000_0FFF;
    localparam logic [IW-1:0] W_POST     = 50'h1_0050_0600_7008;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic drive_stream();
        int i;
        int guard;
        bit took;
        i = 0;
        guard = 0;
        while (i < stim_q.size() && guard < 20000) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = stim_q[i];
            in_last  = send_last && (i == stim_q.size() - 1);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (i < stim_q.size()) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drive_timeout: sent %0d bytes, required %0d", i, stim_q.size());
        end
    endtask

    task automatic collect(input int ready_pct, input int timeout);
        int cycles;
        logic [IW:0] e;
        cycles = 0;
        while ((exp_q.size() > 0 || !parse_done) && cycles < timeout) begin
            instr_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL extra_instr: got last=%b data=%h, required no word", instr_last, instr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr_last, instr_data} !== e) begin
                        n_mismatched++;
                        $display("FAIL instr_word: got last=%b data=%h, required last=%b data=%h",
                                 instr_last, instr_data, e[IW], e[IW-1:0]);
                    end
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (cycles >= timeout) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL collect_timeout: %0d words outstanding, parse_done=%b, required 0 and 1",
                     exp_q.size(), parse_done);
        end
    endtask

    task automatic finish_checks(input int exp_errors);
        n_compared++;
        if (error_count !== exp_errors[EW-1:0]) begin
            n_mismatched++;
            $display("FAIL error_count: got %0d, required %0d", error_count, exp_errors);
        end
        n_compared++;
        if ({parse_done, in_ready, instr_valid} !== 3'b100) begin
            n_mismatched++;
            $display("FAIL done_state: got parse_done=%b in_ready=%b instr_valid=%b, required 1 0 0",
                     parse_done, in_ready, instr_valid);
        end
    endtask

    task automatic run_stream(input int ready_pct);
        fork
            drive_stream();
            collect(ready_pct, 30000);
        join
    endtask

    // ---------------- reference model ----------------
    // Works on whole lines: CR stripped, op from characters 1 and 6,
    // numbers are the decimal runs (mod 4096), exactly four make an instruction.
    task automatic model_line();
        int nums[$];
        int val;
        bit in_run;
        logic [1:0] op;
        if (line_q.size() == 0) return;
        op = 2'b00;
        if (line_q.size() > 1 && line_q[1] == 8'h6f) op = 2'b01;
        else if (line_q.size() > 6 && line_q[6] == 8'h6e) op = 2'b11;
        val = 0;
        in_run = 1'b0;
        foreach (line_q[k]) begin
            if (line_q[k] >= 8'h30 && line_q[k] <= 8'h39) begin
                val = (val * 10 + int'(line_q[k] - 8'h30)) % 4096;
                in_run = 1'b1;
            end else if (in_run) begin
                nums.push_back(val);
                val = 0;
                in_run = 1'b0;
            end
        end
        if (in_run) nums.push_back(val);
        if (nums.size() == 4) begin
            exp_q.push_back({1'b0, op, nums[0][PB-1:0], nums[1][PB-1:0],
                             nums[2][PB-1:0], nums[3][PB-1:0]});
        end else if (exp_err < 255) begin
            exp_err++;
        end
    endtask

    task automatic model_expected();
        logic [7:0] c;
        exp_q.delete();
        line_q.delete();
        exp_err = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            c = stim_q[i];
            if (c != 8'h0d && c != 8'h0a) line_q.push_back(c);
            if (c == 8'h0a || i == stim_q.size() - 1) begin
                model_line();
                line_q.delete();
            end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1][IW] = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if ({in_ready, instr_valid, instr_last, instr_data, parse_done, error_count} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b d=%h done=%b err=%0d st=%0d, required all 0",
                     in_ready, instr_valid, instr_last, instr_data, parse_done, error_count, dbg_state);
        end
        reset_n = 1'b1;
        #1;
        n_compared++;
        if (in_ready !== 1'b0) begin
            n_mismatched++;
            $display("FAIL ready_before_edge: got %b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL ready_after_edge: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single_line();
        reset_dut();
        stim_q.delete();
        push_str("turn on 0,0 through 999,999\n");
        exp_q.delete();
        exp_q.push_back({1'b1, W_ON_FULL});
        send_last = 1'b1;
        gap_pct = 0;
        run_stream(100);
        finish_checks(0);
    endtask

    task automatic test_no_final_newline();
        reset_dut();
        stim_q.delete();
        push_str("toggle 0,0 through 999,0\nturn off 499,499 through 500,500");
        exp_q.delete();
        exp_q.push_back({1'b0, W_TOG});
        exp_q.push_back({1'b1, W_OFF_MID});
        run_stream(100);
        finish_checks(0);
    endtask

    task automatic test_crlf_blank();
        reset_dut();
        stim_q.delete();
        push_str("\r\n\r\ntoggle 0,0 through 999,0\r\n\r\n\nturn off 499,499 through 500,500\r\n\n");
        exp_q.delete();
        exp_q.push_back({1'b0, W_TOG});
        exp_q.push_back({1'b1, W_OFF_MID});
        gap_pct = 25;
        run_stream(70);
        gap_pct = 0;
        finish_checks(0);
    endtask

    task automatic test_malformed();
        reset_dut();
        stim_q.delete();
        push_str("turn on 0,0 through 999,999\nturn on 1,2 through 3\ntoggle 0,0 through 999,0\n");
        exp_q.delete();
        exp_q.push_back({1'b0, W_ON_FULL});
        exp_q.push_back({1'b1, W_TOG});
        run_stream(100);
        finish_checks(1);
    endtask

    task automatic test_error_saturate();
        reset_dut();
        stim_q.delete();
        for (int i = 0; i < 260; i++) push_str("1\n");
        exp_q.delete();
        run_stream(100);
        finish_checks(255);
    endtask

    task automatic test_backpressure();
        int bad;
        bit seen;
        reset_dut();
        stim_q.delete();
        push_str("turn on 1,2 through 3,4\ntoggle 10,20 through 30,40\nturn off 4095,0 through 0,4095\n");
        exp_q.delete();
        exp_q.push_back({1'b0, W_BP1});
        exp_q.push_back({1'b0, W_BP2});
        exp_q.push_back({1'b1, W_BP3});
        bad = 0;
        seen = 1'b0;
        fork
            drive_stream();
            begin
                instr_ready = 1'b0;
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (instr_valid) begin
                        seen = 1'b1;
                        if (instr_data !== W_BP1 || instr_last !== 1'b0) bad++;
                    end else if (seen) begin
                        bad++;
                    end
                end
                n_compared++;
                if (bad != 0 || !seen) begin
                    n_mismatched++;
                    $display("FAIL bp_hold: got %0d unstable cycles (seen=%b), required 0 and seen=1", bad, seen);
                end
                n_compared++;
                if (in_ready !== 1'b0) begin
                    n_mismatched++;
                    $display("FAIL bp_in_ready: got %b, required 0", in_ready);
                end
                @(posedge clk);
                #1;
                collect(100, 5000);
            end
        join
        finish_checks(0);
    endtask

    task automatic test_midstream_reset();
        // Phase A: both registers full, then an asynchronous reset mid-cycle.
        reset_dut();
        stim_q.delete();
        push_str("turn on 1,2 through 3,4\ntoggle 10,20 through 30,40\n");
        send_last = 1'b0;
        instr_ready = 1'b0;
        drive_stream();
        repeat (3) @(posedge clk);
        #2;
        n_compared++;
        if (instr_valid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL mid_precondition: instr_valid got %b, required 1", instr_valid);
        end
        reset_n = 1'b0;
        #1;
        n_compared++;
        if ({instr_valid, in_ready, instr_data} !== '0) begin
            n_mismatched++;
            $display("FAIL async_clear: got v=%b rdy=%b d=%h, required 0 0 0", instr_valid, in_ready, instr_data);
        end
        release_reset();
        // Phase B: a reserved word and a half-parsed line are thrown away by reset.
        stim_q.delete();
        push_str("turn on 1,2 through 3,4\nturn on 7,");
        drive_stream();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        stim_q.delete();
        push_str("toggle 5,6 through 7,8\n");
        send_last = 1'b1;
        exp_q.delete();
        exp_q.push_back({1'b1, W_POST});
        run_stream(100);
        finish_checks(0);
    endtask

    task automatic test_random();
        int n_lines;
        int kind;
        int a, b, c, d;
        string verb;
        string s;
        for (int it = 0; it < 8; it++) begin
            reset_dut();
            stim_q.delete();
            n_lines = $urandom_range(1, 8);
            for (int ln = 0; ln < n_lines; ln++) begin
                kind = $urandom_range(0, 9);
                a = $urandom_range(0, 4999);
                b = $urandom_range(0, 4999);
                c = ($urandom_range(0, 3) == 0) ? 4096 : $urandom_range(0, 999);
                d = ($urandom_range(0, 3) == 0) ? 4095 : $urandom_range(0, 999);
                case ($urandom_range(0, 2))
                    0: verb = "turn on";
                    1: verb = "turn off";
                    default: verb = "toggle";
                endcase
                if (kind == 0) s = "";
                else if (kind == 1) s = $sformatf("%s %0d,%0d through %0d", verb, a, b, c);
                else if (kind == 2) s = $sformatf("%s %0d,%0d through %0d,%0d,%0d", verb, a, b, c, d, a);
                else s = $sformatf("%s %0d,%0d through %0d,%0d", verb, a, b, c, d);
                push_str(s);
                if (ln == n_lines - 1 && kind != 0 && $urandom_range(0, 2) == 0) begin
                    // stream ends on the last character of the line
                end else begin
                    push_str(($urandom_range(0, 1) == 1) ? "\r\n" : "\n");
                    if (ln == n_lines - 1 && $urandom_range(0, 1) == 1) push_str("\n");
                end
            end
            model_expected();
            send_last = 1'b1;
            gap_pct = 20;
            run_stream(60);
            gap_pct = 0;
            finish_checks(exp_err);
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_single_line();
        test_no_final_newline();
        test_crlf_blank();
        test_malformed();
        test_error_saturate();
        test_backpressure();
        test_midstream_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
